// File: rtl/down_counter.sv
// Loadable down-counter timer built from a chain of per-bit borrow cells.
// Decrements on enabled cycles while running. When the count reaches zero it
// pulses o_expired for one cycle, then halts (the default build) or reloads.
// Optional feature macro: DOWN_COUNTER_AUTORELOAD_EN (when defined, the counter
// reloads from the reload register instead of halting at zero).

module down_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_expired,
    output logic             o_zero
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_busy;
    logic             r_expired;

    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_reload_next;
    logic             w_busy_next;
    logic             w_expired_next;

    logic             w_dec;
    logic             w_count_is_one;
    logic             w_load_is_zero;
    logic [WIDTH-1:0] w_borrow;
    logic [WIDTH-1:0] w_count_dec;

    // Decrement request: running, enabled, and not overridden by load or reset
    assign w_dec          = (r_state == ST_RUN) & i_enable & ~i_load & ~i_reset;
    assign w_count_is_one = (r_count == WIDTH'(1));
    assign w_load_is_zero = (i_load_value == '0);

    // Borrow chain: each cell toggles on borrow-in, and passes the borrow on while its bit is 0
    assign w_borrow[0] = w_dec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign w_count_dec[i] = r_count[i] ^ w_borrow[i];
        if (i + 1 < WIDTH) begin : g_link
            assign w_borrow[i+1] = w_borrow[i] & ~r_count[i];
        end
    end

    // Next-state and next-output logic; load beats decrement, reset is applied in the registers
    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_reload_next  = r_reload;
        w_expired_next = 1'b0;

        if (i_load) begin
            w_count_next  = i_load_value;
            w_reload_next = i_load_value;
            if (w_load_is_zero) begin
                w_state_next   = ST_EXPIRED;
                w_expired_next = 1'b1;
            end else begin
                w_state_next   = ST_RUN;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_IDLE;
                end
                ST_RUN: begin
                    if (w_dec) begin
                        if (w_count_is_one) begin
                            w_expired_next = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                            w_count_next   = r_reload;
                            w_state_next   = ST_RUN;
`else
                            w_count_next   = w_count_dec;
                            w_state_next   = ST_EXPIRED;
`endif
                        end else begin
                            w_count_next   = w_count_dec;
                        end
                    end
                end
                ST_EXPIRED: begin
                    w_state_next = ST_EXPIRED;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end

        w_busy_next = (w_state_next == ST_RUN);
    end

    // State register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Count, reload and registered status outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count   <= '0;
            r_reload  <= '0;
            r_busy    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_reload  <= w_reload_next;
            r_busy    <= w_busy_next;
            r_expired <= w_expired_next;
        end
    end

    assign o_count   = r_count;
    assign o_busy    = r_busy;
    assign o_expired = r_expired;
    assign o_zero    = (r_count == '0);

endmodule

// File: doc/down_counter.md
# down_counter

Loadable down-counter timer built as a chain of per-bit borrow cells, the decrementing counterpart of the team's up-counter carry chain. Software or a controller loads a start value; the block decrements by one on each enabled cycle, signals expiry with a one-cycle pulse when the count reaches zero, and then either halts or reloads, depending on build configuration. It sits beside the existing counters as the timeout and interval source for sequencing logic.

## Interface
- `WIDTH`, default 3: count width in bits; legal range 1..16.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous reset, active-high.
- `load` input 1: load `load_value` into the count and into the reload register.
- `load_value` input WIDTH: start value, unsigned.
- `enable` input 1: decrement qualifier; sampled only in RUN.
- `count` output WIDTH: current count, registered.
- `busy` output 1: high while in RUN, registered.
- `expired` output 1: one-cycle pulse on reaching zero, registered.
- `zero` output 1: combinational, `count == 0`.

## Operation
- **Internal structure**
  - One borrow cell per bit.
  - Bit 0 `borrow_in` is `dec`, where `dec` = state RUN & `enable` & no `load` & no `reset`.
  - Cell `i` toggles its bit when `borrow_in` is 1.
  - `borrow_out` = `borrow_in` & ~bit.
  - `borrow_out` of bit i feeds `borrow_in` of bit i+1.
  - The MSB `borrow_out` is unused; underflow is impossible, because the count never decrements from 0.
- **State machine: IDLE, RUN, EXPIRED**
  - **IDLE**: after reset. `enable` is ignored and `count` holds. `load` with a nonzero value goes to RUN; `load` with 0 goes to EXPIRED.
  - **RUN**:
    - `enable`=0: `count` holds.
    - `enable`=1 and count>1: `count` <= count-1.
    - `enable`=1 and count==1: `count` <= 0, the state goes to EXPIRED, and `expired` <= 1.
  - **EXPIRED**: `count`=0 and holds; `enable` is ignored. Only `load` leaves this state, with the same rules as in IDLE.
- **Priority**: `reset` > `load` > decrement.
  - `load` in any state overwrites `count` and the reload register and does not pulse `expired`.
  - Exception: `load` of 0 pulses `expired` and enters EXPIRED.
- **Outputs by state**
  - `busy` = 1 exactly when state is RUN.
  - `expired` is 1 for exactly one cycle per expiry event.
  - `expired` is never asserted in the same cycle as `busy` rising from a nonzero load.
- **Arithmetic**: unsigned, modulo 2^WIDTH is never reached. Largest load is 2^WIDTH-1, which gives exactly that many enabled cycles to expiry.

## Timing
- **Reset values**: `count`=0, `busy`=0, `expired`=0, reload register=0, state IDLE.
- **Reset mid-operation**: all of the above values appear in the cycle after the `reset` edge, regardless of `load` or `enable`.
- **Load latency**: `load` at edge N gives `count`=`load_value` and `busy`=1 after edge N (visible in cycle N+1).
- **Expiry latency**: the enabled edge that takes count 1 to 0 also sets `expired`=1 and `busy`=0 in the following cycle. `expired` clears on the next edge.
- **Enabled-cycle count**: load value V (V>0) with `enable` held high reaches `count`=0 exactly V edges after the load edge.
- **`load` in the expiry cycle**: when `load` arrives in the same cycle that would expire the count, the load wins and no `expired` pulse occurs.

## Configuration
- **Macro**: `DOWN_COUNTER_AUTORELOAD_EN`.
- **Defined**:
  - In RUN with `enable`=1 and count==1, `count` <= reload register and the state stays RUN.
  - `expired` pulses for one cycle in the following cycle, and `busy` stays 1.
  - The period is V enabled cycles, and `count` never shows 0 during RUN.
  - `load` of 0 still goes to EXPIRED and does not reload.
- **Undefined**: one-shot behaviour as in Operation. The reload register is still written but not used for reload.

## Test plan
- **Basic countdown**: WIDTH=3; `reset`; `load` 5 with `enable`=1 held -> `count` 5,4,3,2,1,0. `expired`=1 only in the cycle `count` first reads 0. `busy` goes 1 then 0 at that cycle. `count` stays 0 afterwards.
- **Enable gating**: `load` 3; `enable` pattern 1,0,1,1 -> `count` 3,2,2,1,0. `enable` ignored in IDLE and EXPIRED, so `count` holds.
- **Zero load and max load**:
  - `load` 0 -> `count`=0, `busy`=0, `expired` one-cycle pulse.
  - `load` 7 with `enable` high -> expiry after exactly 7 edges.
- **Reload mid-run**:
  - At `count`=2, `load` 6 -> `count`=6, `busy`=1, no `expired`.
  - `load` asserted in the 1->0 cycle -> no pulse, `count`=load value.
- **Reset mid-run**: at `count`=4, assert `reset` together with `load` 2 -> next cycle `count`=0, `busy`=0, `expired`=0, IDLE.
- **Autoreload** (`DOWN_COUNTER_AUTORELOAD_EN` defined): `load` 3, `enable` high -> `count` 3,2,1,3,2,1. `expired` pulses every 3 edges and `busy` stays 1. Without the macro, the same stimulus halts at 0.
